// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, shifts
// start/data/parity/stop on device falling edges and samples the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2148,
  parameter int TIMEOUT_CYCLES = 322155,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);
  localparam int CNT_W = 19;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  logic             clk_p0, clk_p1, data_p0, data_p1;
  logic [FLT_W-1:0] clk_fcnt, data_fcnt;
  logic             clk_flt, data_flt, clk_flt_d;
  logic             fall;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [9:0]       frame, frame_n;
  logic             armed, armed_n;
  logic             clk_o_q, clk_o_n, data_o_q, data_o_n;
  logic             ack_q, ack_n, done_q, done_n, err_q, err_n;
  logic             timeout;

  // Synchronizer (p0/p1) followed by a stability filter on each line
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      data_p0   <= 1'b1;
      data_p1   <= 1'b1;
      clk_flt   <= 1'b1;
      data_flt  <= 1'b1;
      clk_flt_d <= 1'b1;
      clk_fcnt  <= '0;
      data_fcnt <= '0;
    end else begin
      clk_p0    <= ps2_clk_i;
      clk_p1    <= clk_p0;
      data_p0   <= ps2_data_i;
      data_p1   <= data_p0;
      clk_flt_d <= clk_flt;
      if (clk_p1 == clk_flt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_flt  <= clk_p1;
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + FLT_W'(1);
      end
      if (data_p1 == data_flt) begin
        data_fcnt <= '0;
      end else if (data_fcnt == FLT_W'(FILTER_LEN - 1)) begin
        data_flt  <= data_p1;
        data_fcnt <= '0;
      end else begin
        data_fcnt <= data_fcnt + FLT_W'(1);
      end
    end
  end

  assign fall    = clk_flt_d & ~clk_flt;
  assign timeout = !fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Control state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      armed    <= 1'b0;
      clk_o_q  <= 1'b1;
      data_o_q <= 1'b1;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      armed    <= armed_n;
      clk_o_q  <= clk_o_n;
      data_o_q <= data_o_n;
      ack_q    <= ack_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    frame <= frame_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    frame_n  = frame;
    armed_n  = armed;
    clk_o_n  = clk_o_q;
    data_o_n = data_o_q;
    ack_n    = ack_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        clk_o_n  = 1'b1;
        data_o_n = 1'b1;
        if (tx_valid) begin
          // Frame word shifted LSB first: data, odd parity, stop
          frame_n = {1'b1, ~^tx_data, tx_data};
          ack_n   = 1'b0;
          cnt_n   = '0;
          clk_o_n = 1'b0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_o_n = 1'b0;
          state_n  = RTS;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RTS: begin
        clk_o_n = 1'b1;
        cnt_n   = '0;
        idx_n   = '0;
        armed_n = 1'b0;
        state_n = SEND;
      end
      SEND, ACK, WAIT_IDLE: begin
        cnt_n = fall ? '0 : cnt + CNT_W'(1);
        if (state == WAIT_IDLE && clk_flt && data_flt) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          clk_o_n  = 1'b1;
          data_o_n = 1'b1;
          err_n    = 1'b1;
          state_n  = IDLE;
        end else if (state == SEND) begin
          // Ignore edges until the released clock has been seen high
          armed_n = armed | clk_flt;
          if (fall && armed) begin
            data_o_n = frame[idx];
            idx_n    = idx + 4'd1;
            if (idx == 4'd9) state_n = ACK;
          end
        end else if (state == ACK && fall) begin
          ack_n   = ~data_flt;
          state_n = WAIT_IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_ready   = (state == IDLE);
  assign tx_done    = done_q;
  assign tx_ack     = ack_q;
  assign tx_error   = err_q;
  assign ps2_clk_o  = clk_o_q;
  assign ps2_data_o = data_o_q;

endmodule
